// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode stage plus ID/EX pipeline register for a
// MIPS-style pipeline.
//
// Holds the 32x32 register file (r0 hard-wired to zero), decodes the fetched
// instruction, reads its rs/rt operands with write-back bypass (and optional
// EX/MEM forwarding), detects data hazards and either registers the decoded
// instruction into the EX stage or inserts a bubble.
//
// Build option: define ID_EX_FORWARD_EN to enable EX/MEM forwarding. Then only
// load-use hazards stall. Without it, any used source that matches a pending
// EX or EX/MEM destination stalls.
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   if_valid, if_instr                instruction from fetch
//   id_ready                          fetch instruction accepted this cycle
//   flush                             squash the fetch instruction (branch taken)
//   wb_we, wb_addr, wb_data           register-file write port (MEM/WB)
//   exmem_we, exmem_addr, exmem_data  EX/MEM result for forwarding
//   ex_valid, ex_instr                EX stage instruction and its validity
//   ex_rega, ex_regb                  rs / rt operand values
//   ex_dest, ex_we, ex_memread        destination, write enable, load flag
module id_ex_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        id_ready,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_addr,
  input  logic [31:0] exmem_data,
  output logic        ex_valid,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_regA,
  output logic [31:0] ex_regB,
  output logic [4:0]  ex_dest,
  output logic        ex_we,
  output logic        ex_memread
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010,
    OP_SLTIU = 6'b001011,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  logic [31:0] rf [32];

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        use_rs;
  logic        use_rt;
  logic        writes;
  logic [4:0]  wdest;
  logic        dec_we;
  logic [4:0]  dec_dest;
  logic        dec_memread;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hazard;
  logic        accept;

  assign opcode = if_instr[31:26];
  assign func   = if_instr[5:0];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];

  // Register file; r0 is never written and is also forced to zero on read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Source usage and destination decode.
  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    writes = 1'b0;
    wdest  = '0;
    case (opcode)
      OP_RTYPE: begin
        // Shift-immediate forms take their operand from rt only.
        use_rs = !(func == 6'b000000 || func == 6'b000010 || func == 6'b000011);
        use_rt = 1'b1;
        writes = 1'b1;
        wdest  = rd;
      end
      OP_BEQ, OP_BNE, OP_SW: use_rt = 1'b1;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: begin
        writes = 1'b1;
        wdest  = rt;
      end
      default: ;
    endcase
    dec_we      = writes && (wdest != '0);
    dec_dest    = dec_we ? wdest : '0;
    dec_memread = (opcode == OP_LW);
  end

  // Operand read: EX/MEM forward over WB bypass over register file.
  always_comb begin
    op_a = rf[rs];
    op_b = rf[rt];
    if (wb_we && wb_addr != '0 && wb_addr == rs) op_a = wb_data;
    if (wb_we && wb_addr != '0 && wb_addr == rt) op_b = wb_data;
`ifdef ID_EX_FORWARD_EN
    if (exmem_we && exmem_addr != '0 && exmem_addr == rs) op_a = exmem_data;
    if (exmem_we && exmem_addr != '0 && exmem_addr == rt) op_b = exmem_data;
`endif
    if (rs == '0) op_a = '0;
    if (rt == '0) op_b = '0;
  end

  function automatic logic src_hit(input logic [4:0] a, input logic urs, input logic urt,
                                   input logic [4:0] s, input logic [4:0] t);
    return (urs && s == a) || (urt && t == a);
  endfunction

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    hazard = ex_valid && ex_memread && (ex_dest != '0) &&
             src_hit(ex_dest, use_rs, use_rt, rs, rt);
  end
`else
  // ex_we is only ever set with a non-zero ex_dest, so no separate zero check.
  always_comb begin
    hazard = (ex_we && src_hit(ex_dest, use_rs, use_rt, rs, rt)) ||
             (exmem_we && exmem_addr != '0 && src_hit(exmem_addr, use_rs, use_rt, rs, rt));
  end

  logic unused_exmem_data;
  assign unused_exmem_data = ^exmem_data;
`endif

  // A squashed or absent instruction never stalls; flush wins over a hazard.
  assign id_ready = !(if_valid && !flush && hazard);
  assign accept   = if_valid && !flush && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_instr   <= RESET_INSTR;
      ex_regA    <= '0;
      ex_regB    <= '0;
      ex_dest    <= '0;
      ex_we      <= 1'b0;
      ex_memread <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_instr   <= if_instr;
      ex_regA    <= op_a;
      ex_regB    <= op_b;
      ex_dest    <= dec_dest;
      ex_we      <= dec_we;
      ex_memread <= dec_memread;
    end else begin
      ex_valid   <= 1'b0;
      ex_instr   <= RESET_INSTR;
      ex_regA    <= '0;
      ex_regB    <= '0;
      ex_dest    <= '0;
      ex_we      <= 1'b0;
      ex_memread <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: reset checks, a table of decode vectors, hand
// sequences for stall/flush/reset/forwarding corners, and a randomized run
// against a reference model. Honors ID_EX_FORWARD_EN like the design.
module tb_id_ex_stage;

  localparam logic [31:0] RI = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exmem_we;
  logic [4:0]  exmem_addr;
  logic [31:0] exmem_data;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_regA;
  logic [31:0] ex_regB;
  logic [4:0]  ex_dest;
  logic        ex_we;
  logic        ex_memread;

  always #5 clk = ~clk;

  id_ex_stage #(.RESET_INSTR(RI)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_we(exmem_we), .exmem_addr(exmem_addr), .exmem_data(exmem_data),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_regA(ex_regA), .ex_regB(ex_regB),
    .ex_dest(ex_dest), .ex_we(ex_we), .ex_memread(ex_memread)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         input logic we, input logic mr);
    chk({tag, ".valid"}, ex_valid, v);
    chk({tag, ".instr"}, ex_instr, ins);
    chk({tag, ".regA"}, ex_regA, a);
    chk({tag, ".regB"}, ex_regB, b);
    chk({tag, ".we"}, ex_we, we);
    chk({tag, ".memread"}, ex_memread, mr);
    if (we) chk({tag, ".dest"}, ex_dest, d);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic xwe, input logic [4:0] xa, input logic [31:0] xd);
    if_valid = v; if_instr = ins; flush = fl;
    wb_we = wwe; wb_addr = wa; wb_data = wd;
    exmem_we = xwe; exmem_addr = xa; exmem_data = xd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_dest;
  logic        m_we;
  logic        m_mr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_instr = RI; m_a = '0; m_b = '0; m_dest = '0; m_we = 0; m_mr = 0;
  endtask

  // Which sources an instruction reads and which register it writes.
  function automatic void decode(input logic [31:0] ins, output bit ur, output bit ut,
                                 output bit w, output logic [4:0] d, output bit ld);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    ur = 1; ut = 0; w = 0; d = '0; ld = (op == 6'h23);
    if (op == 6'h00) begin
      ur = !(fn inside {6'h00, 6'h02, 6'h03});
      ut = 1; w = 1; d = ins[15:11];
    end else if (op inside {6'h04, 6'h05, 6'h2B}) begin
      ut = 1;
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23}) begin
      w = 1; d = ins[20:16];
    end
    if (d == 0) w = 0;
    if (!w) d = '0;
  endfunction

  function automatic bit uses(input logic [31:0] ins, input logic [4:0] r);
    bit ur, ut, w, ld;
    logic [4:0] d;
    decode(ins, ur, ut, w, d, ld);
    return (ur && ins[25:21] == r) || (ut && ins[20:16] == r);
  endfunction

  function automatic bit m_stall();
    if (!if_valid || flush) return 0;
`ifdef ID_EX_FORWARD_EN
    return m_valid && m_mr && m_dest != 0 && uses(if_instr, m_dest);
`else
    return (m_we && m_dest != 0 && uses(if_instr, m_dest)) ||
           (exmem_we && exmem_addr != 0 && uses(if_instr, exmem_addr));
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return '0;
`ifdef ID_EX_FORWARD_EN
    if (exmem_we && exmem_addr == r) return exmem_data;
`endif
    if (wb_we && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit ur, ut, w, ld;
    logic [4:0] d;
    if (if_valid && !flush && !m_stall()) begin
      decode(if_instr, ur, ut, w, d, ld);
      m_valid = 1; m_instr = if_instr;
      m_a = m_read(if_instr[25:21]); m_b = m_read(if_instr[20:16]);
      m_dest = d; m_we = w; m_mr = ld;
    end else begin
      m_valid = 0; m_instr = RI; m_a = '0; m_b = '0; m_dest = '0; m_we = 0; m_mr = 0;
    end
    if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] s, t, d;
    logic [15:0] imm;
    int unsigned k;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k = $urandom_range(0, 11);
    case (k)
      0: return {6'h00, s, t, d, 5'd0, 6'h20};
      1: return {6'h00, s, t, d, 5'd3, 6'h00};
      2: return {6'h00, s, t, d, 5'd1, 6'h02};
      3: return {6'h00, s, t, d, 5'd2, 6'h03};
      4: return {6'h00, s, t, d, 5'd0, 6'h25};
      5: return {6'h08, s, t, imm};
      6: return {6'h0D, s, t, imm};
      7, 8: return {6'h23, s, t, imm};
      9: return {6'h2B, s, t, imm};
      10: return {6'h04, s, t, imm};
      default: return {6'h3F, s, t, imm};
    endcase
  endfunction

  task automatic do_reset();
    drive(0, '0, 0, 0, '0, '0, 0, '0, '0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        flush;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0]  ed;
    logic        ewe;
    logic        emr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] i, input logic f,
                              input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rdy, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [4:0] ed, input logic ewe, input logic emr);
    vec_t r;
    r.valid = v; r.instr = i; r.flush = f; r.wwe = wwe; r.wa = wa; r.wd = wd;
    r.rdy = rdy; r.ev = ev; r.ei = ei; r.ea = ea; r.eb = eb; r.ed = ed;
    r.ewe = ewe; r.emr = emr;
    return r;
  endfunction

  localparam logic [31:0] ADD_R3_R5_R5 = 32'h00A5_1820;
  localparam logic [31:0] LW_R4_R1     = 32'h8C24_0000;
  localparam logic [31:0] ADD_R6_R4_R2 = 32'h0082_3020;
  localparam logic [31:0] OR_R8_R7_R0  = 32'h00E0_4025;

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(0, 32'h0,        0, 1, 5'd5,  32'h0000_1234, 1, 0, RI, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, ADD_R3_R5_R5, 0, 0, 5'd0,  32'h0, 1, 1, ADD_R3_R5_R5, 32'h1234, 32'h1234, 3, 1, 0);
    tbl[2]  = mk(1, 32'h20A7_0010, 0, 1, 5'd9, 32'hAAAA_5555, 1, 1, 32'h20A7_0010, 32'h1234, 0, 7, 1, 0);
    tbl[3]  = mk(1, 32'h0149_5822, 0, 1, 5'd10, 32'h0BAD_F00D, 1, 1, 32'h0149_5822, 32'h0BAD_F00D, 32'hAAAA_5555, 11, 1, 0);
    tbl[4]  = mk(1, 32'h016A_6100, 0, 0, 5'd0, 32'h0, 1, 1, 32'h016A_6100, 0, 32'h0BAD_F00D, 12, 1, 0);
    tbl[5]  = mk(1, 32'hACA9_0008, 0, 0, 5'd0, 32'h0, 1, 1, 32'hACA9_0008, 32'h1234, 32'hAAAA_5555, 0, 0, 0);
    tbl[6]  = mk(1, LW_R4_R1,     0, 0, 5'd0, 32'h0, 1, 1, LW_R4_R1, 0, 0, 4, 1, 1);
    tbl[7]  = mk(1, ADD_R6_R4_R2, 0, 0, 5'd0, 32'h0, 0, 0, RI, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, ADD_R6_R4_R2, 0, 0, 5'd0, 32'h0, 1, 1, ADD_R6_R4_R2, 0, 0, 6, 1, 0);
    tbl[9]  = mk(1, 32'h10A9_0003, 0, 0, 5'd0, 32'h0, 1, 1, 32'h10A9_0003, 32'h1234, 32'hAAAA_5555, 0, 0, 0);
    tbl[10] = mk(1, ADD_R3_R5_R5, 1, 0, 5'd0, 32'h0, 1, 0, RI, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 32'hFCA9_0000, 0, 0, 5'd0, 32'h0, 1, 1, 32'hFCA9_0000, 32'h1234, 32'hAAAA_5555, 0, 0, 0);
    tbl[12] = mk(1, 32'h340D_0001, 0, 1, 5'd0, 32'hFFFF_FFFF, 1, 1, 32'h340D_0001, 0, 0, 13, 1, 0);
    tbl[13] = mk(1, 32'h0000_7021, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0000_7021, 0, 0, 14, 1, 0);
    tbl[14] = mk(1, 32'h00A5_0020, 0, 0, 5'd0, 32'h0, 1, 1, 32'h00A5_0020, 32'h1234, 32'h1234, 0, 0, 0);
    tbl[15] = mk(0, ADD_R3_R5_R5, 0, 0, 5'd0, 32'h0, 1, 0, RI, 0, 0, 0, 0, 0);

    drive(0, '0, 0, 0, '0, '0, 0, '0, '0);
    #1 rst = 1;
    #1;
    chk_out("reset", 0, RI, 0, 0, 0, 0, 0);
    chk("reset.dest", ex_dest, 0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Table vectors.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].valid, tbl[i].instr, tbl[i].flush, tbl[i].wwe, tbl[i].wa, tbl[i].wd, 0, '0, '0);
      #1 chk($sformatf("tbl%0d.ready", i), id_ready, tbl[i].rdy);
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ea, tbl[i].eb,
              tbl[i].ed, tbl[i].ewe, tbl[i].emr);
    end

    // EX/MEM result vs. same-cycle WB write to the same register.
    do_reset();
    drive(1, OR_R8_R7_R0, 0, 1, 5'd7, 32'h11, 1, 5'd7, 32'hDEAD_BEEF);
`ifdef ID_EX_FORWARD_EN
    #1 chk("fwd.ready", id_ready, 1);
    tick();
    chk_out("fwd", 1, OR_R8_R7_R0, 32'hDEAD_BEEF, 0, 8, 1, 0);
`else
    #1 chk("nofwd.ready0", id_ready, 0);
    tick();
    chk("nofwd.bubble0", ex_valid, 0);
    drive(1, OR_R8_R7_R0, 0, 0, '0, '0, 1, 5'd7, 32'hDEAD_BEEF);
    #1 chk("nofwd.ready1", id_ready, 0);
    tick();
    chk("nofwd.bubble1", ex_valid, 0);
    drive(1, OR_R8_R7_R0, 0, 0, '0, '0, 0, '0, '0);
    #1 chk("nofwd.ready2", id_ready, 1);
    tick();
    chk_out("nofwd", 1, OR_R8_R7_R0, 32'h11, 0, 8, 1, 0);
`endif

    // Load-use stall coinciding with flush.
    do_reset();
    drive(1, LW_R4_R1, 0, 0, '0, '0, 0, '0, '0);
    tick();
    drive(1, ADD_R6_R4_R2, 1, 0, '0, '0, 0, '0, '0);
    #1 chk("flush.ready", id_ready, 1);
    tick();
    chk_out("flush", 0, RI, 0, 0, 0, 0, 0);

    // Reset pulse in the middle of a load-use stall.
    do_reset();
    drive(1, LW_R4_R1, 0, 0, '0, '0, 0, '0, '0);
    tick();
    drive(1, ADD_R6_R4_R2, 0, 0, '0, '0, 0, '0, '0);
    #1 chk("rststall.ready0", id_ready, 0);
    rst = 1;
    #1;
    chk_out("rststall.async", 0, RI, 0, 0, 0, 0, 0);
    chk("rststall.ready1", id_ready, 1);
    @(negedge clk);
    rst = 0;
    #1 chk("rststall.ready2", id_ready, 1);
    tick();
    chk_out("rststall.issue", 1, ADD_R6_R4_R2, 0, 0, 6, 1, 0);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)), $urandom);
      #1 chk($sformatf("rnd%0d.ready", c), id_ready, !m_stall());
      model_edge();
      tick();
      chk_out($sformatf("rnd%0d", c), m_valid, m_instr, m_a, m_b, m_dest, m_we, m_mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
